mem_stage: RTL and testbench

- Memory-access pipeline stage between the execute stage and the writeback stage.
- Accepts the execute-stage result bus and waits for the data SRAM response to any request execute issued.
- Aligns and extends load data, and forwards the result to writeback and to decode-stage bypass logic.
- Tracks responses belonging to flushed requests and discards them, so a stale response never retires a younger instruction.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_load_align.sv | 32 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and load-type bit positions for the memory stage.
// Imported by mem_stage and mem_load_align.
package mem_stage_pkg;

  localparam int EX_MEM_W  = 77;
  localparam int EXC_W     = 86;
  localparam int MEM_WB_W  = 70;
  localparam int RF_BUS_W  = 39;
  localparam int DISCARD_W = 2;

  // ld_type = {ld_w, ld_b, ld_h, ld_bu, ld_hu}
  localparam int LD_W_BIT  = 4;
  localparam int LD_B_BIT  = 3;
  localparam int LD_H_BIT  = 2;
  localparam int LD_BU_BIT = 1;
  localparam int LD_HU_BIT = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ld_type;
    logic        res_from_mem;
    logic        req_issued;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] final_result;
  } mem_wb_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: picks the byte/half addressed by off and
// sign- or zero-extends it; ld_w returns the whole word.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [4:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];

    result = '0;
    if (ld_type[LD_W_BIT])       result = word;
    else if (ld_type[LD_B_BIT])  result = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_type[LD_BU_BIT]) result = {24'd0, byte_sel};
    else if (ld_type[LD_H_BIT])  result = {{16{half_sel[15]}}, half_sel};
    else if (ld_type[LD_HU_BIT]) result = {16'd0, half_sel};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data SRAM responses, aligns loads,
// and discards responses of flushed requests. MEM_LD_STALL_CNT_EN adds ld_stall_cnt.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic                mem_allowin,
  input  logic                ex_mem_valid,
  input  logic [EX_MEM_W-1:0] ex_mem_bus,
  input  logic [EXC_W-1:0]    ex_except_bus,
  input  logic                wb_allowin,
  output logic                mem_wb_valid,
  output logic [MEM_WB_W-1:0] mem_wb_bus,
  output logic [EXC_W-1:0]    mem_except_bus,
  output logic                mem_exc_signal,
  output logic [RF_BUS_W-1:0] mem_rf_bus,
  input  logic                wb_flush,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata
`ifdef MEM_LD_STALL_CNT_EN
  ,
  output logic [31:0]         ld_stall_cnt
`endif
);

  ex_mem_t ex_in;
  ex_mem_t mem_r;
  logic mem_valid;
  logic buf_valid;
  logic [31:0] rdata_buf;
  logic [DISCARD_W-1:0] discard_cnt;
  logic [DISCARD_W:0]   discard_sum;
  logic own_ok;
  logic drop_ok;
  logic waiting;
  logic mem_ready_go;
  logic leave;
  logic data_pending;
  logic [31:0] load_word;
  logic [31:0] aligned;
  logic [31:0] final_result;

  assign ex_in = ex_mem_t'(ex_mem_bus);

  assign own_ok       = data_sram_data_ok & (discard_cnt == '0);
  assign drop_ok      = data_sram_data_ok & (discard_cnt != '0);
  assign waiting      = mem_valid & mem_r.req_issued & ~buf_valid;
  assign mem_ready_go = ~mem_r.req_issued | buf_valid | own_ok;
  assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_wb_valid = mem_valid & mem_ready_go;
  assign leave        = mem_wb_valid & wb_allowin;

  always_ff @(posedge clk) begin
    if (!resetn)          mem_valid <= 1'b0;
    else if (wb_flush)    mem_valid <= 1'b0;
    else if (mem_allowin) mem_valid <= ex_mem_valid;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_r          <= '0;
      mem_except_bus <= '0;
    end else if (ex_mem_valid & mem_allowin) begin
      mem_r          <= ex_in;
      mem_except_bus <= ex_except_bus;
    end
  end

  // A response that arrives while writeback is stalled is held here so it is
  // delivered exactly once.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      rdata_buf <= '0;
    end else begin
      if (wb_flush | leave)     buf_valid <= 1'b0;
      else if (own_ok & waiting) buf_valid <= 1'b1;
      if (own_ok & waiting)     rdata_buf <= data_sram_rdata;
    end
  end

  // On a flush, requests still in flight (the waiting MEM load unless its
  // response lands this cycle, plus any EX request) become responses to drop.
  always_comb begin
    discard_sum = {1'b0, discard_cnt} - {{DISCARD_W{1'b0}}, drop_ok};
    if (wb_flush)
      discard_sum = discard_sum
                  + {{DISCARD_W{1'b0}}, waiting & ~own_ok}
                  + {{DISCARD_W{1'b0}}, ex_mem_valid & ex_in.req_issued};
  end

  always_ff @(posedge clk) begin
    if (!resetn) discard_cnt <= '0;
    else         discard_cnt <= discard_sum[DISCARD_W-1:0];
  end

  a_discard_no_overflow: assert property (
    @(posedge clk) disable iff (!resetn) discard_sum <= 3'd3);

  assign load_word = buf_valid ? rdata_buf : data_sram_rdata;

  mem_load_align u_align (
    .word    (load_word),
    .off     (mem_r.alu_result[1:0]),
    .ld_type (mem_r.ld_type),
    .result  (aligned)
  );

  assign final_result   = mem_r.res_from_mem ? aligned : mem_r.alu_result;
  assign mem_wb_bus     = {mem_r.pc, mem_r.rf_we, mem_r.rf_waddr, final_result};
  assign mem_exc_signal = mem_valid & (|mem_except_bus);
  assign data_pending   = mem_valid & mem_r.res_from_mem & ~mem_ready_go;
  assign mem_rf_bus     = {data_pending, mem_r.rf_we & mem_valid & ~mem_exc_signal,
                           mem_r.rf_waddr, final_result};

`ifdef MEM_LD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn)                                    ld_stall_cnt <= '0;
    else if (mem_valid & mem_r.req_issued & ~mem_ready_go) ld_stall_cnt <= ld_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks with inline checks and
// a writeback-side scoreboard fed when instructions enter the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [4:0] T_NONE = 5'b00000;
  localparam logic [4:0] T_W    = 5'b10000;
  localparam logic [4:0] T_B    = 5'b01000;
  localparam logic [4:0] T_H    = 5'b00100;
  localparam logic [4:0] T_BU   = 5'b00010;
  localparam logic [4:0] T_HU   = 5'b00001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic mem_allowin;
  logic ex_mem_valid;
  logic [EX_MEM_W-1:0] ex_mem_bus;
  logic [EXC_W-1:0] ex_except_bus;
  logic wb_allowin;
  logic mem_wb_valid;
  logic [MEM_WB_W-1:0] mem_wb_bus;
  logic [EXC_W-1:0] mem_except_bus;
  logic mem_exc_signal;
  logic [RF_BUS_W-1:0] mem_rf_bus;
  logic wb_flush;
  logic data_sram_data_ok;
  logic [31:0] data_sram_rdata;
`ifdef MEM_LD_STALL_CNT_EN
  logic [31:0] ld_stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  mem_wb_t sb[$];
  mem_wb_t mon_exp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_allowin       (mem_allowin),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_bus        (ex_mem_bus),
    .ex_except_bus     (ex_except_bus),
    .wb_allowin        (wb_allowin),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_bus        (mem_wb_bus),
    .mem_except_bus    (mem_except_bus),
    .mem_exc_signal    (mem_exc_signal),
    .mem_rf_bus        (mem_rf_bus),
    .wb_flush          (wb_flush),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
`ifdef MEM_LD_STALL_CNT_EN
    ,
    .ld_stall_cnt      (ld_stall_cnt)
`endif
  );

  // Writeback side: every accepted transfer must match the oldest expected entry.
  always begin
    @(negedge clk);
    #4;
    if (resetn === 1'b1 && wb_flush === 1'b0 && mem_wb_valid === 1'b1 && wb_allowin === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_extra_delivery got %h expected none", mem_wb_bus);
      end else begin
        mon_exp = sb.pop_front();
        if (mem_wb_bus !== mon_exp)
          $display("FAIL sb_wb_bus got %h expected %h", mem_wb_bus, mon_exp);
        else n_pass++;
      end
    end
  end

  function automatic ex_mem_t mk(input logic [31:0] pc, input logic [4:0] lt,
                                 input logic rfm, input logic req, input logic we,
                                 input logic [4:0] wa, input logic [31:0] alu);
    ex_mem_t b;
    b.pc = pc; b.ld_type = lt; b.res_from_mem = rfm; b.req_issued = req;
    b.rf_we = we; b.rf_waddr = wa; b.alu_result = alu;
    return b;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [4:0] lt);
    logic [31:0] sb8;
    logic [31:0] sh16;
    sb8  = word >> {off, 3'b000};
    sh16 = word >> {off[1], 4'b0000};
    case (lt)
      T_B:     return {{24{sb8[7]}}, sb8[7:0]};
      T_BU:    return {24'd0, sb8[7:0]};
      T_H:     return {{16{sh16[15]}}, sh16[15:0]};
      T_HU:    return {16'd0, sh16[15:0]};
      default: return word;
    endcase
  endfunction

  task automatic idle_inputs();
    ex_mem_valid = 1'b0;
    ex_mem_bus = '0;
    ex_except_bus = '0;
    wb_allowin = 1'b1;
    wb_flush = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
  endtask

  task automatic enter(input ex_mem_t b, input logic [EXC_W-1:0] exc, input bit push,
                       input logic [31:0] exp_res);
    mem_wb_t e;
    @(negedge clk);
    idle_inputs();
    ex_mem_valid = 1'b1;
    ex_mem_bus = b;
    ex_except_bus = exc;
    #1;
    n_total++;
    if (mem_allowin !== 1'b1) $display("FAIL enter_allowin got %b expected 1", mem_allowin);
    else n_pass++;
    if (push) begin
      e = '{b.pc, b.rf_we, b.rf_waddr, exp_res};
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input logic ok, input logic [31:0] rd, input logic alw);
    @(negedge clk);
    idle_inputs();
    data_sram_data_ok = ok;
    data_sram_rdata = rd;
    wb_allowin = alw;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_total++; if (mem_wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b expected 0", mem_wb_valid); else n_pass++;
    n_total++; if (mem_wb_bus !== '0) $display("FAIL rst_wb_bus got %h expected 0", mem_wb_bus); else n_pass++;
    n_total++; if (mem_rf_bus !== '0) $display("FAIL rst_rf_bus got %h expected 0", mem_rf_bus); else n_pass++;
    n_total++; if (mem_except_bus !== '0) $display("FAIL rst_exc_bus got %h expected 0", mem_except_bus); else n_pass++;
    n_total++; if (mem_exc_signal !== 1'b0) $display("FAIL rst_exc_sig got %b expected 0", mem_exc_signal); else n_pass++;
    n_total++; if (mem_allowin !== 1'b1) $display("FAIL rst_allowin got %b expected 1", mem_allowin); else n_pass++;
  endtask

  task automatic test_ld_b();
    enter(mk(32'h100, T_B, 1, 1, 1, 5'd3, 32'h1003), '0, 1, 32'hFFFF_FF80);
    cyc(1, 32'h80FF_1234, 1);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL ldb_valid got %b expected 1", mem_wb_valid); else n_pass++;
    n_total++; if (mem_wb_bus[31:0] !== 32'hFFFF_FF80) $display("FAIL ldb_result got %h expected ffffff80", mem_wb_bus[31:0]); else n_pass++;
    n_total++; if (mem_rf_bus[38] !== 1'b0) $display("FAIL ldb_pending got %b expected 0", mem_rf_bus[38]); else n_pass++;
    cyc(0, 32'h0, 1);
    n_total++; if (mem_wb_valid !== 1'b0) $display("FAIL ldb_one_cycle got %b expected 0", mem_wb_valid); else n_pass++;
  endtask

  task automatic test_ld_hu_late();
    logic [31:0] c0;
    enter(mk(32'h104, T_HU, 1, 1, 1, 5'd7, 32'h2002), '0, 1, 32'h0000_BEEF);
    c0 = '0;
`ifdef MEM_LD_STALL_CNT_EN
    c0 = ld_stall_cnt;
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 1);
      n_total++; if (mem_rf_bus[38] !== 1'b1) $display("FAIL ldhu_pending[%0d] got %b expected 1", i, mem_rf_bus[38]); else n_pass++;
      n_total++; if (mem_allowin !== 1'b0) $display("FAIL ldhu_allowin[%0d] got %b expected 0", i, mem_allowin); else n_pass++;
    end
    cyc(1, 32'hBEEF_0000, 1);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL ldhu_valid got %b expected 1", mem_wb_valid); else n_pass++;
    n_total++; if (mem_wb_bus[31:0] !== 32'h0000_BEEF) $display("FAIL ldhu_result got %h expected 0000beef", mem_wb_bus[31:0]); else n_pass++;
    n_total++; if (mem_rf_bus[38] !== 1'b0) $display("FAIL ldhu_pending_end got %b expected 0", mem_rf_bus[38]); else n_pass++;
`ifdef MEM_LD_STALL_CNT_EN
    n_total++; if (ld_stall_cnt !== c0 + 32'd3) $display("FAIL ldhu_stall_cnt got %0d expected %0d", ld_stall_cnt, c0 + 32'd3); else n_pass++;
`endif
  endtask

  task automatic test_ld_w_buffered();
    enter(mk(32'h108, T_W, 1, 1, 1, 5'd9, 32'h3000), '0, 1, 32'h1234_5678);
    cyc(1, 32'h1234_5678, 0);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL buf_valid_first got %b expected 1", mem_wb_valid); else n_pass++;
    n_total++; if (mem_allowin !== 1'b0) $display("FAIL buf_allowin got %b expected 0", mem_allowin); else n_pass++;
    cyc(0, 32'hDEAD_BEEF, 0);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL buf_valid_hold got %b expected 1", mem_wb_valid); else n_pass++;
    n_total++; if (mem_wb_bus[31:0] !== 32'h1234_5678) $display("FAIL buf_result_hold got %h expected 12345678", mem_wb_bus[31:0]); else n_pass++;
    n_total++; if (mem_rf_bus[38] !== 1'b0) $display("FAIL buf_pending got %b expected 0", mem_rf_bus[38]); else n_pass++;
    cyc(0, 32'hDEAD_BEEF, 1);
    n_total++; if (mem_wb_bus[31:0] !== 32'h1234_5678) $display("FAIL buf_result_deliver got %h expected 12345678", mem_wb_bus[31:0]); else n_pass++;
    cyc(0, 32'h0, 1);
    n_total++; if (mem_wb_valid !== 1'b0) $display("FAIL buf_no_dup got %b expected 0", mem_wb_valid); else n_pass++;
  endtask

  task automatic test_discard();
    enter(mk(32'h10C, T_W, 1, 1, 1, 5'd10, 32'h4000), '0, 0, 32'h0);
    @(negedge clk);
    idle_inputs();
    ex_mem_valid = 1'b1;
    ex_mem_bus = mk(32'h110, T_W, 1, 1, 1, 5'd11, 32'h4004);
    wb_flush = 1'b1;
    #1;
    n_total++; if (mem_allowin !== 1'b0) $display("FAIL dis_allowin_flush got %b expected 0", mem_allowin); else n_pass++;
    enter(mk(32'h114, T_W, 1, 1, 1, 5'd12, 32'h4008), '0, 1, 32'h0C0F_FEE3);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hAAAA_0001;
    #1;
    n_total++; if (dut.discard_cnt !== 2'd2) $display("FAIL dis_cnt_two got %0d expected 2", dut.discard_cnt); else n_pass++;
    n_total++; if (mem_wb_valid !== 1'b0) $display("FAIL dis_drop1_valid got %b expected 0", mem_wb_valid); else n_pass++;
    cyc(1, 32'hAAAA_0002, 1);
    n_total++; if (mem_wb_valid !== 1'b0) $display("FAIL dis_drop2_valid got %b expected 0", mem_wb_valid); else n_pass++;
    n_total++; if (mem_rf_bus[38] !== 1'b1) $display("FAIL dis_drop2_pending got %b expected 1", mem_rf_bus[38]); else n_pass++;
    cyc(0, 32'h0, 1);
    n_total++; if (dut.discard_cnt !== 2'd0) $display("FAIL dis_cnt_zero got %0d expected 0", dut.discard_cnt); else n_pass++;
    n_total++; if (mem_rf_bus[38] !== 1'b1) $display("FAIL dis_wait_pending got %b expected 1", mem_rf_bus[38]); else n_pass++;
    cyc(1, 32'h0C0F_FEE3, 1);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL dis_third_valid got %b expected 1", mem_wb_valid); else n_pass++;
    n_total++; if (mem_wb_bus[31:0] !== 32'h0C0F_FEE3) $display("FAIL dis_third_result got %h expected 0c0ffee3", mem_wb_bus[31:0]); else n_pass++;
  endtask

  task automatic test_store();
    enter(mk(32'h118, T_NONE, 0, 1, 0, 5'd0, 32'h5000), '0, 1, 32'h5000);
    cyc(0, 32'h0, 1);
    n_total++; if (mem_wb_valid !== 1'b0) $display("FAIL st_wait_valid got %b expected 0", mem_wb_valid); else n_pass++;
    n_total++; if (mem_rf_bus[38] !== 1'b0) $display("FAIL st_pending got %b expected 0", mem_rf_bus[38]); else n_pass++;
    cyc(1, 32'hFFFF_FFFF, 1);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL st_valid got %b expected 1", mem_wb_valid); else n_pass++;
    n_total++; if (mem_wb_bus[31:0] !== 32'h5000) $display("FAIL st_result got %h expected 00005000", mem_wb_bus[31:0]); else n_pass++;
    n_total++; if (mem_wb_bus[37] !== 1'b0) $display("FAIL st_wb_rf_we got %b expected 0", mem_wb_bus[37]); else n_pass++;
    n_total++; if (mem_rf_bus[37] !== 1'b0) $display("FAIL st_byp_rf_we got %b expected 0", mem_rf_bus[37]); else n_pass++;
  endtask

  task automatic test_exception();
    logic [EXC_W-1:0] exc;
    exc = '0;
    exc[3] = 1'b1;
    enter(mk(32'h11C, T_NONE, 0, 0, 1, 5'd5, 32'h55), exc, 1, 32'h55);
    cyc(0, 32'h0, 1);
    n_total++; if (mem_exc_signal !== 1'b1) $display("FAIL exc_signal got %b expected 1", mem_exc_signal); else n_pass++;
    n_total++; if (mem_rf_bus[37] !== 1'b0) $display("FAIL exc_byp_rf_we got %b expected 0", mem_rf_bus[37]); else n_pass++;
    n_total++; if (mem_rf_bus[36:32] !== 5'd5) $display("FAIL exc_byp_waddr got %0d expected 5", mem_rf_bus[36:32]); else n_pass++;
    n_total++; if (mem_except_bus !== exc) $display("FAIL exc_bus got %h expected %h", mem_except_bus, exc); else n_pass++;
    cyc(0, 32'h0, 1);
    n_total++; if (mem_exc_signal !== 1'b0) $display("FAIL exc_signal_clear got %b expected 0", mem_exc_signal); else n_pass++;
  endtask

  task automatic test_align_table();
    logic [4:0] lts [8];
    logic [1:0] offs [8];
    logic [31:0] word;
    logic [31:0] exp_res;
    lts  = '{T_B, T_B, T_B, T_BU, T_H, T_H, T_HU, T_W};
    offs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};
    for (int i = 0; i < 8; i++) begin
      word = $urandom;
      if (i % 2 == 0) word = word | 32'h8080_8080;
      else            word = word & 32'h7F7F_7F7F;
      exp_res = model_load(word, offs[i], lts[i]);
      enter(mk(32'h200 + 32'(i) * 4, lts[i], 1, 1, 1, 5'(i + 1), {28'h000_0100, 2'b00, offs[i]}),
            '0, 1, exp_res);
      cyc(1, word, 1);
      n_total++;
      if (mem_wb_bus[31:0] !== exp_res)
        $display("FAIL align[%0d] got %h expected %h", i, mem_wb_bus[31:0], exp_res);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    ex_mem_t b;
    mem_wb_t e;
    for (int i = 0; i < 6; i++) begin
      b = mk(32'h300 + 32'(i) * 4, T_NONE, 0, 0, 1, 5'(i + 20), $urandom);
      @(negedge clk);
      idle_inputs();
      ex_mem_valid = 1'b1;
      ex_mem_bus = b;
      #1;
      n_total++; if (mem_allowin !== 1'b1) $display("FAIL b2b_allowin[%0d] got %b expected 1", i, mem_allowin); else n_pass++;
      if (i > 0) begin
        n_total++; if (mem_rf_bus[37] !== 1'b1) $display("FAIL b2b_byp_we[%0d] got %b expected 1", i, mem_rf_bus[37]); else n_pass++;
      end
      e = '{b.pc, b.rf_we, b.rf_waddr, b.alu_result};
      sb.push_back(e);
    end
    cyc(0, 32'h0, 1);
  endtask

  task automatic test_reset_mid_wait();
    enter(mk(32'h400, T_W, 1, 1, 1, 5'd1, 32'h6000), '0, 0, 32'h0);
    @(negedge clk);
    idle_inputs();
    ex_mem_valid = 1'b1;
    ex_mem_bus = mk(32'h404, T_W, 1, 1, 1, 5'd2, 32'h6004);
    wb_flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_total++; if (dut.discard_cnt !== 2'd0) $display("FAIL rmw_cnt got %0d expected 0", dut.discard_cnt); else n_pass++;
    enter(mk(32'h408, T_W, 1, 1, 1, 5'd3, 32'h6008), '0, 1, 32'h600D_F00D);
    cyc(1, 32'h600D_F00D, 1);
    n_total++; if (mem_wb_valid !== 1'b1) $display("FAIL rmw_first_resp got %b expected 1", mem_wb_valid); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ld_b();
    test_ld_hu_late();
    test_ld_w_buffered();
    test_discard();
    test_store();
    test_exception();
    test_align_table();
    test_back_to_back();
    test_reset_mid_wait();
    cyc(0, 32'h0, 1);
    repeat (3) @(negedge clk);
    #5;
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
